// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: shared widths, sequencer state encoding and ALU opcodes
package alu_uart_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF = 6;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/byte_timeout_counter.sv
// byte_timeout_counter: counts idle cycles between bytes, flags the last allowed one
module byte_timeout_counter #(
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [TIMEOUT_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    r_cnt <= (i_reset || i_clear) ? '0 : i_enable ? r_cnt + 1'b1 : r_cnt;
  assign o_expired = i_enable && (r_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: gathers A/B/opcode bytes from the UART, runs the ALU, sends the result
import alu_uart_pkg::*;
module alu_uart_sequencer #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [DATA_W-1:0] i_rx_data,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic              o_overrun
);
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_alu_a, r_alu_b, r_tx_data;
  logic [OP_W-1:0] r_alu_op;
  logic r_tx_start, r_err_timeout, r_overrun;
  logic w_collect, w_expired, w_timeout, w_drop;
  logic w_ld_a, w_ld_b, w_ld_op, w_ld_tx;

  assign w_collect = (r_state == S_GET_B) || (r_state == S_GET_OP);
  assign w_timeout = w_collect && w_expired && !i_rx_done;

  byte_timeout_counter #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (!w_collect || i_rx_done || w_timeout),
    .i_enable  (w_collect),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk)
    r_state <= i_reset ? S_IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = i_rx_done ? S_GET_B : S_IDLE;
      S_GET_B:   w_next = i_rx_done ? S_GET_OP : w_timeout ? S_IDLE : S_GET_B;
      S_GET_OP:  w_next = i_rx_done ? S_EXEC : w_timeout ? S_IDLE : S_GET_OP;
      S_EXEC:    w_next = S_SEND;
      S_SEND:    w_next = S_WAIT_TX;
      S_WAIT_TX: w_next = i_tx_done ? S_IDLE : S_WAIT_TX;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld_a  = i_rx_done && (r_state == S_IDLE);
    w_ld_b  = i_rx_done && (r_state == S_GET_B);
    w_ld_op = i_rx_done && (r_state == S_GET_OP);
    w_ld_tx = (r_state == S_EXEC);
    w_drop  = i_rx_done && (r_state == S_EXEC || r_state == S_SEND || r_state == S_WAIT_TX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_ld_a) r_alu_a <= i_rx_data;
      if (w_ld_b) r_alu_b <= i_rx_data;
      if (w_ld_op) r_alu_op <= i_rx_data[OP_W-1:0];
      if (w_ld_tx) r_tx_data <= i_alu_result;
      r_tx_start    <= w_ld_tx;
      r_err_timeout <= w_timeout;
      r_overrun     <= w_drop;
    end
  end

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_err_timeout = r_err_timeout;
  assign o_overrun     = r_overrun;
  assign o_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: directed frames with a scoreboard checking every transmitted result
import alu_uart_pkg::*;
module tb_alu_uart_sequencer;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic rx_done = 1'b0, tx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_a, alu_b, alu_res, tx_data;
  logic [5:0] alu_op;
  logic tx_start, busy, err_timeout, overrun;
  exp_t q[$];
  int n_vec = 0, n_err = 0, n_to = 0, n_ovr = 0, cyc = 0, t_rx = 0;

  alu_uart_sequencer #(.DATA_W(8), .OP_W(6), .TIMEOUT_W(20), .TIMEOUT_CYC(16)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_rx_done     (rx_done),
    .i_rx_data     (rx_data),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .o_alu_op      (alu_op),
    .i_alu_result  (alu_res),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_done     (tx_done),
    .o_busy        (busy),
    .o_err_timeout (err_timeout),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $unsigned($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction
  assign alu_res = alu(alu_a, alu_b, alu_op);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (err_timeout) n_to++;
      if (overrun) n_ovr++;
      if (tx_start && prev) chk("tx_start_width", 32'd2, 32'd1);
      else if (tx_start) begin
        if (q.size() == 0) chk("unexpected_tx_start", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("tx_data", tx_data, e.res);
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          chk("alu_op", alu_op, e.op);
          chk("tx_latency", cyc - t_rx, 2);
        end
      end
      prev = tx_start;
    end
  endtask

  task automatic rx(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    t_rx = cyc;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [5:0] eop, input logic [7:0] res, input bit mid_ovr, input bit btb);
    int k = 0;
    exp_t e;
    e.a = a; e.b = b; e.op = eop; e.res = res;
    q.push_back(e);
    rx(a); rx(b); rx(op);
    while (!tx_start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("tx_start_seen", tx_start, 1);
    repeat (2) @(posedge clk);
    #1;
    if (mid_ovr) begin
      rx(8'h77);
      chk("overrun_pulse", overrun, 1);
      chk("busy_after_overrun", busy, 1);
      @(posedge clk); #1;
      chk("overrun_one_cycle", overrun, 0);
    end
    tx_done = 1'b1;
    rx_done = btb;
    rx_data = 8'h99;
    @(posedge clk); #1;
    tx_done = 1'b0;
    rx_done = 1'b0;
    chk("busy_after_tx_done", busy, 0);
    if (btb) chk("btb_overrun", overrun, 1);
  endtask

  initial begin
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_flags", {tx_start, busy, err_timeout, overrun}, 0);
    frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 0, 0);
    frame(8'h10, 8'h01, 8'hE2, 6'h22, 8'h0F, 0, 0);
    rx(8'hAA);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_before_expiry", busy, 1);
    chk("no_early_timeout", err_timeout, 0);
    @(posedge clk); #1;
    chk("timeout_pulse", err_timeout, 1);
    chk("idle_after_timeout", busy, 0);
    chk("a_kept_after_timeout", alu_a, 8'hAA);
    @(posedge clk); #1;
    chk("timeout_one_cycle", err_timeout, 0);
    frame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 0, 0);
    rx(8'h11);
    repeat (15) @(posedge clk);
    #1;
    rx(8'h22);
    chk("boundary_no_timeout", err_timeout, 0);
    chk("boundary_b", alu_b, 8'h22);
    chk("boundary_busy", busy, 1);
    begin
      exp_t e;
      e.a = 8'h11; e.b = 8'h22; e.op = 6'h20; e.res = 8'h33;
      q.push_back(e);
    end
    rx(8'h20);
    repeat (4) @(posedge clk);
    #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk("boundary_done", busy, 0);
    frame(8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF, 1, 0);
    frame(8'h04, 8'h04, 8'h24, 6'h24, 8'h04, 0, 1);
    frame(8'h0C, 8'h03, 8'h26, 6'h26, 8'h0F, 0, 0);
    rx(8'h55); rx(8'h66);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_flags", {tx_start, busy, err_timeout, overrun}, 0);
    repeat (5) @(posedge clk);
    #1;
    frame(8'h80, 8'h01, 8'h03, 6'h03, 8'hC0, 0, 0);
    frame(8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_count", n_to, 1);
    chk("overrun_count", n_ovr, 2);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
